// File: rtl/regfile.sv
// 32 x DATA_W register file, two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Latency: reads 0 cycles (write data bypassed in the write cycle); writes visible from storage next cycle.
// Backpressure: none; every read and write request is serviced in the cycle it is presented.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   localparam int DEPTH = 1 << ADDR_W;

   // Only r1..r(DEPTH-1) exist as flops; r0 is a constant zero in the read view.
   logic [DATA_W-1:0] regs [1:DEPTH-1];
   logic [DATA_W-1:0] rd_view [0:DEPTH-1];

   // A write that would land in r0 is dropped here rather than masked on read.
   logic wr_hit;
   assign wr_hit = we && (waddr != '0);

   // Storage update: async clear on reset, otherwise load the addressed register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr_hit && (waddr == ADDR_W'(i))) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   // Flat read view so both ports can use a single 32:1 mux indexed by address.
   always_comb begin
      rd_view[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
         rd_view[i] = regs[i];
      end
   end

   // Port 1 read: reset, enable and r0 force zero; same-cycle write is bypassed.
   always_comb begin
      rdata1 = '0;
      if (!rst || !re1 || (raddr1 == '0)) begin
         rdata1 = '0;
      end else if (we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = rd_view[raddr1];
      end
   end

   // Port 2 read: identical to port 1 and fully independent of it.
   always_comb begin
      rdata2 = '0;
      if (!rst || !re2 || (raddr2 == '0)) begin
         rdata2 = '0;
      end else if (we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = rd_view[raddr2];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Directed test of the register file: reset, write/read, r0, bypass and port independence.
// Latency: expectations sampled 1 time unit after input changes or after the write edge.
// Backpressure: not applicable; the block has no handshake.
module tb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int checks = 0;
   int errors = 0;

   regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait for a rising edge and step just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
      #3;
      check("reset_rd1", rdata1, 32'h0);
      check("reset_rd2", rdata2, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_reset_r5", rdata1, 32'h0);

      // Reset clear: write r5, then assert reset between edges.
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
      #1;
      check("r5_written", rdata1, 32'hDEADBEEF);
      #1;
      rst = 1'b0;
      #1;
      check("reset_async_rd1", rdata1, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("r5_cleared", rdata1, 32'h0);

      // Basic write/read on successive edges.
      @(negedge clk);
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
      tick();
      waddr = 5'd31; wdata = 32'hFFFF0000;
      tick();
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd31;
      #1;
      check("r7_rd1", rdata1, 32'h12345678);
      check("r31_rd2", rdata2, 32'hFFFF0000);
      re1 = 1'b0; re2 = 1'b0;
      #1;
      check("re1_off", rdata1, 32'h0);
      check("re2_off", rdata2, 32'h0);

      // Register zero: write attempt, read in write cycle and after.
      re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
      we = 1'b1; waddr = 5'd0; wdata = 32'hAAAAAAAA;
      #1;
      check("r0_wcyc_rd1", rdata1, 32'h0);
      check("r0_wcyc_rd2", rdata2, 32'h0);
      tick();
      we = 1'b0;
      #1;
      check("r0_after_rd1", rdata1, 32'h0);
      check("r0_after_rd2", rdata2, 32'h0);
      tick();
      check("r0_later_rd1", rdata1, 32'h0);

      // Bypass: r9 = 0x11 then overwrite with 0x22 while reading on both ports.
      we = 1'b1; waddr = 5'd9; wdata = 32'h00000011;
      tick();
      we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd9;
      #1;
      check("r9_old", rdata1, 32'h00000011);
      we = 1'b1; waddr = 5'd9; wdata = 32'h00000022;
      #1;
      check("byp_rd1", rdata1, 32'h00000022);
      check("byp_rd2", rdata2, 32'h00000022);
      tick();
      we = 1'b0;
      #1;
      check("r9_store_rd1", rdata1, 32'h00000022);
      check("r9_store_rd2", rdata2, 32'h00000022);

      // Write lost under reset; reset also discards r9 and r7.
      rst = 1'b0;
      we = 1'b1; waddr = 5'd3; wdata = 32'h5A5A5A5A;
      tick();
      we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      raddr1 = 5'd3; raddr2 = 5'd9;
      #1;
      check("r3_lost", rdata1, 32'h0);
      check("r9_cleared", rdata2, 32'h0);
      raddr1 = 5'd7;
      #1;
      check("r7_cleared", rdata1, 32'h0);

      // Independent ports: write r4 while reading r4 (bypass) and r6 (storage).
      we = 1'b1; waddr = 5'd6; wdata = 32'h00000006;
      tick();
      waddr = 5'd4; wdata = 32'h00000001;
      raddr1 = 5'd4; raddr2 = 5'd6;
      #1;
      check("indep_rd1_byp", rdata1, 32'h00000001);
      check("indep_rd2_r6", rdata2, 32'h00000006);
      re1 = 1'b0;
      #1;
      check("byp_masked_by_re", rdata1, 32'h0);
      tick();
      we = 1'b0; re1 = 1'b1;
      #1;
      check("r4_stored", rdata1, 32'h00000001);
      check("r6_kept", rdata2, 32'h00000006);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
